// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: four-channel input handshake plus registered output port
interface rr_mux_arbiter_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] d_in;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  modport master (
    output a_in, b_in, c_in, d_in, in_valid, out_ready,
    input  in_ready, sel, out, out_valid
  );
  modport slave (
    input  a_in, b_in, c_in, d_in, in_valid, out_ready,
    output in_ready, sel, out, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin 4:1 grant with a one-deep registered output stage
module rr_mux_arbiter #(parameter int WIDTH = 4) (
  input logic            clk,
  input logic            rst,
  rr_mux_arbiter_if.slave bus
);
  logic [1:0]       ptr;
  logic [1:0]       g;
  logic             slot_free;
  logic             grant;
  logic [WIDTH-1:0] din [4];
  assign din       = '{bus.a_in, bus.b_in, bus.c_in, bus.d_in};
  assign slot_free = !bus.out_valid || bus.out_ready;
  assign grant     = !rst && slot_free && |bus.in_valid;
  assign bus.in_ready = grant ? 4'(1) << g : 4'b0000;
  // first valid channel at or after ptr; descending scan lets the nearest one win
  always_comb begin
    g = ptr;
    for (int k = 3; k >= 0; k--)
      if (bus.in_valid[ptr + 2'(k)]) g = ptr + 2'(k);
  end
  // output register loads on grant, drains when empty, holds under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.sel       <= 2'd0;
      ptr           <= 2'd0;
    end else if (slot_free) begin
      bus.out_valid <= grant;
      if (grant) begin
        bus.out <= din[g];
        bus.sel <= g;
        ptr     <= g + 2'd1;
      end
    end
  end
endmodule
